// File: rtl/guess_entry_controller.sv
// Numberle guess-path controller: keypad digit entry, delete/submit handling,
// per-digit scoring against the secret, feedback LEDs and seven-segment scan.
module guess_entry_controller #(
    parameter int MAX_GUESSES = 6,
    parameter int SCAN_BIT    = 18
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        btnR,
    input  logic        btnL,
    input  logic [15:0] secret,
    output logic [3:0]  anode,
    output logic [3:0]  hex_out,
    output logic [15:0] led,
    output logic        win,
    output logic        game_over
);

    // Only the bits up to the scan position are observable, so the scan
    // counter stops there; at the default SCAN_BIT this is the full 20 bits.
    localparam int CNT_W = SCAN_BIT + 2;

    typedef enum logic [1:0] {
        ENTRY = 2'd0,
        SCORE = 2'd1,
        WON   = 2'd2,
        LOST  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         k_q, k_d;
    logic [15:0]        buf_q, buf_d;
    logic [2:0]         cursor_q, cursor_d;
    logic [3:0]         count_q, count_d;
    logic               all_exact_q, all_exact_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               btnr_prev_q, btnl_prev_q;
    logic [3:0]         anode_q, anode_d;
    logic [3:0]         hex_q, hex_d;
    logic [15:0]        led_q, led_d;

    logic               btnr_rise, btnl_rise;
    logic [1:0]         del_idx;
    logic [3:0]         guess_nib;
    logic [1:0]         digit_fb;
    logic [15:0]        disp_src;
    logic [1:0]         scan_pos;
    logic [3:0]         scan_nib;

    function automatic logic [7:0] thermo(input logic [3:0] n);
        logic [7:0] t;
        for (int i = 0; i < 8; i++) begin
            t[i] = (4'(i) < n);
        end
        return t;
    endfunction

    // Exact match wins; otherwise any other secret position holding the same
    // digit counts as misplaced, with no multiplicity accounting.
    function automatic logic [1:0] score_digit(input logic [3:0] g,
                                               input logic [15:0] sec,
                                               input logic [1:0] k);
        logic present;
        present = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if ((j[1:0] != k) && (sec[4*j +: 4] == g)) begin
                present = 1'b1;
            end
        end
        if (sec[{k, 2'b00} +: 4] == g) begin
            return 2'b10;
        end else if (present) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    assign btnr_rise = btnR & ~btnr_prev_q;
    assign btnl_rise = btnL & ~btnl_prev_q;
    assign del_idx   = cursor_q[1:0] - 2'd1;
    assign guess_nib = buf_q[{k_q, 2'b00} +: 4];
    assign digit_fb  = score_digit(guess_nib, secret, k_q);

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        buf_d       = buf_q;
        cursor_d    = cursor_q;
        count_d     = count_q;
        all_exact_d = all_exact_q;
        led_d       = led_q;

        case (state_q)
            ENTRY: begin
                if (btnl_rise && (cursor_q != 3'd0)) begin
                    cursor_d = cursor_q - 3'd1;
                    buf_d[{del_idx, 2'b00} +: 4] = 4'hF;
                end else if (key_valid && (key_code <= 4'd9) && (cursor_q < 3'd4)) begin
                    buf_d[{cursor_q[1:0], 2'b00} +: 4] = key_code;
                    cursor_d = cursor_q + 3'd1;
                end else if (btnr_rise && (cursor_q == 3'd4)) begin
                    state_d     = SCORE;
                    k_d         = 2'd0;
                    all_exact_d = 1'b1;
                end
            end
            SCORE: begin
                led_d[{k_q, 1'b0} +: 2] = digit_fb;
                all_exact_d = all_exact_q & (digit_fb == 2'b10);
                if (k_q == 2'd3) begin
                    if (all_exact_q && (digit_fb == 2'b10)) begin
                        state_d = WON;
                    end else begin
                        count_d = count_q + 4'd1;
                        led_d[15:8] = thermo(count_d);
                        if (count_d == 4'(MAX_GUESSES)) begin
                            state_d = LOST;
                        end else begin
                            state_d  = ENTRY;
                            buf_d    = 16'hFFFF;
                            cursor_d = 3'd0;
                        end
                    end
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            default: begin
                // WON and LOST hold until reset
            end
        endcase
    end

    assign cnt_d    = cnt_q + 1'b1;
    assign disp_src = (state_q == LOST) ? secret : buf_q;
    assign scan_pos = cnt_q[SCAN_BIT+1:SCAN_BIT];
    assign scan_nib = disp_src[{scan_pos, 2'b00} +: 4];

    // A blank digit turns every anode off and leaves hex_out where it was.
    always_comb begin
        anode_d = 4'hF;
        hex_d   = hex_q;
        if (scan_nib != 4'hF) begin
            hex_d = scan_nib;
            case (scan_pos)
                2'd0:    anode_d = 4'b0111;
                2'd1:    anode_d = 4'b1011;
                2'd2:    anode_d = 4'b1101;
                default: anode_d = 4'b1110;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ENTRY;
            k_q         <= 2'd0;
            buf_q       <= 16'hFFFF;
            cursor_q    <= 3'd0;
            count_q     <= 4'd0;
            all_exact_q <= 1'b0;
            cnt_q       <= '0;
            btnr_prev_q <= 1'b1;
            btnl_prev_q <= 1'b1;
            anode_q     <= 4'hF;
            hex_q       <= 4'h0;
            led_q       <= 16'h0000;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            buf_q       <= buf_d;
            cursor_q    <= cursor_d;
            count_q     <= count_d;
            all_exact_q <= all_exact_d;
            cnt_q       <= cnt_d;
            btnr_prev_q <= btnR;
            btnl_prev_q <= btnL;
            anode_q     <= anode_d;
            hex_q       <= hex_d;
            led_q       <= led_d;
        end
    end

    assign anode     = anode_q;
    assign hex_out   = hex_q;
    assign led       = led_q;
    assign win       = (state_q == WON);
    assign game_over = (state_q == WON) || (state_q == LOST);

endmodule

// File: tb/tb_guess_entry_controller.sv
// Directed bench for guess_entry_controller: table-driven entry/delete vectors
// plus hand-written scoring, loss, win and reset sequences.
module tb_guess_entry_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        btnR;
    logic        btnL;
    logic [15:0] secret;
    logic [3:0]  anode;
    logic [3:0]  hex_out;
    logic [15:0] led;
    logic        win;
    logic        game_over;

    int checks   = 0;
    int failures = 0;

    guess_entry_controller #(
        .MAX_GUESSES(2),
        .SCAN_BIT   (0)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .key_valid(key_valid),
        .key_code (key_code),
        .btnR     (btnR),
        .btnL     (btnL),
        .secret   (secret),
        .anode    (anode),
        .hex_out  (hex_out),
        .led      (led),
        .win      (win),
        .game_over(game_over)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        kv;
        logic [3:0]  kc;
        logic        bl;
        logic        br;
        logic [15:0] exp_disp;
        logic        exp_go;
    } vec_t;

    vec_t vecs[13];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Rebuild the displayed 4-digit word from one full scan (4 cycles at SCAN_BIT=0).
    task automatic read_display(output logic [15:0] v);
        v = 16'hFFFF;
        for (int c = 0; c < 4; c++) begin
            tick();
            case (anode)
                4'b0111: v[3:0]   = hex_out;
                4'b1011: v[7:4]   = hex_out;
                4'b1101: v[11:8]  = hex_out;
                4'b1110: v[15:12] = hex_out;
                default: ;
            endcase
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        check("rst_anode", 32'(anode), 32'hF);
        check("rst_hex", 32'(hex_out), 32'h0);
        check("rst_led", 32'(led), 32'h0);
        check("rst_go", 32'({win, game_over}), 32'h0);
        reset = 1'b0;
    endtask

    task automatic press_key(input logic [3:0] d);
        key_valid = 1'b1;
        key_code  = d;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic enter4(input logic [3:0] d0, input logic [3:0] d1,
                          input logic [3:0] d2, input logic [3:0] d3);
        press_key(d0);
        press_key(d1);
        press_key(d2);
        press_key(d3);
    endtask

    task automatic submit();
        btnR = 1'b1;
        tick();
        btnR = 1'b0;
    endtask

    logic [15:0] disp;

    initial begin
        reset     = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        btnR      = 1'b0;
        btnL      = 1'b0;
        secret    = 16'h4321;

        //             kv    kc     bl    br    disp       go
        vecs[0]  = '{1'b1, 4'h1, 1'b0, 1'b0, 16'hFFF1, 1'b0};
        vecs[1]  = '{1'b1, 4'h2, 1'b0, 1'b0, 16'hFF21, 1'b0};
        vecs[2]  = '{1'b1, 4'h3, 1'b0, 1'b0, 16'hF321, 1'b0};
        vecs[3]  = '{1'b0, 4'h0, 1'b1, 1'b0, 16'hFF21, 1'b0};
        vecs[4]  = '{1'b0, 4'h0, 1'b0, 1'b1, 16'hFF21, 1'b0};
        vecs[5]  = '{1'b1, 4'hA, 1'b0, 1'b0, 16'hFF21, 1'b0};
        vecs[6]  = '{1'b1, 4'h3, 1'b0, 1'b0, 16'hF321, 1'b0};
        vecs[7]  = '{1'b1, 4'h4, 1'b0, 1'b0, 16'h4321, 1'b0};
        vecs[8]  = '{1'b1, 4'h5, 1'b0, 1'b0, 16'h4321, 1'b0};
        vecs[9]  = '{1'b0, 4'h0, 1'b1, 1'b0, 16'hF321, 1'b0};
        vecs[10] = '{1'b0, 4'h0, 1'b1, 1'b0, 16'hFF21, 1'b0};
        vecs[11] = '{1'b1, 4'h7, 1'b1, 1'b0, 16'hFFF1, 1'b0};
        vecs[12] = '{1'b0, 4'h0, 1'b1, 1'b0, 16'hFFFF, 1'b0};

        do_reset();
        read_display(disp);
        check("reset_disp", 32'(disp), 32'hFFFF);

        for (int i = 0; i < 13; i++) begin
            key_valid = vecs[i].kv;
            key_code  = vecs[i].kc;
            btnL      = vecs[i].bl;
            btnR      = vecs[i].br;
            tick();
            key_valid = 1'b0;
            btnL      = 1'b0;
            btnR      = 1'b0;
            read_display(disp);
            check($sformatf("vec%0d_disp", i), 32'(disp), 32'(vecs[i].exp_disp));
            check($sformatf("vec%0d_go", i), 32'(game_over), 32'(vecs[i].exp_go));
        end

        // Delete at cursor 0 is ignored
        btnL = 1'b1;
        tick();
        btnL = 1'b0;
        read_display(disp);
        check("del_empty", 32'(disp), 32'hFFFF);

        // Wrong guess 5,1,2,9: per-digit LED timing after the submit edge
        enter4(4'h5, 4'h1, 4'h2, 4'h9);
        submit();
        key_valid = 1'b1;
        key_code  = 4'h7;
        tick();
        key_valid = 1'b0;
        check("wrong_t2", 32'(led), 32'h0000);
        tick();
        check("wrong_t3", 32'(led), 32'h0004);
        tick();
        check("wrong_t4", 32'(led), 32'h0014);
        check("wrong_t4_go", 32'(game_over), 32'h0);
        tick();
        check("wrong_t5", 32'(led), 32'h0114);
        check("wrong_t5_go", 32'({win, game_over}), 32'h0);
        read_display(disp);
        check("wrong_buf_clear", 32'(disp), 32'hFFFF);

        // Second wrong guess reaches MAX_GUESSES=2 -> LOST
        enter4(4'h8, 4'h8, 4'h8, 4'h8);
        submit();
        for (int c = 0; c < 4; c++) tick();
        check("lost_led", 32'(led), 32'h0300);
        check("lost_flags", 32'({win, game_over}), 32'h1);
        read_display(disp);
        check("lost_disp", 32'(disp), 32'h4321);
        press_key(4'h6);
        btnL = 1'b1;
        tick();
        btnL = 1'b0;
        read_display(disp);
        check("lost_disp_after_keys", 32'(disp), 32'h4321);
        check("lost_hold", 32'({win, game_over}), 32'h1);

        // Reset mid-SCORE discards the partial guess
        do_reset();
        enter4(4'h5, 4'h1, 4'h2, 4'h9);
        submit();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_led", 32'(led), 32'h0000);
        check("midrst_go", 32'(game_over), 32'h0);
        read_display(disp);
        check("midrst_disp", 32'(disp), 32'hFFFF);
        enter4(4'h8, 4'h8, 4'h8, 4'h8);
        submit();
        for (int c = 0; c < 4; c++) tick();
        check("midrst_count", 32'(led), 32'h0100);
        check("midrst_not_lost", 32'(game_over), 32'h0);

        // btnR held across reset does not submit; then a real submit wins
        btnR  = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        enter4(4'h1, 4'h2, 4'h3, 4'h4);
        for (int c = 0; c < 6; c++) tick();
        check("held_btnr_go", 32'({win, game_over}), 32'h0);
        read_display(disp);
        check("held_btnr_disp", 32'(disp), 32'h4321);
        btnR = 1'b0;
        tick();
        submit();
        for (int c = 0; c < 3; c++) tick();
        check("win_t4_led", 32'(led), 32'h002A);
        check("win_t4_flag", 32'({win, game_over}), 32'h0);
        tick();
        check("win_t5_led", 32'(led), 32'h00AA);
        check("win_t5_flag", 32'({win, game_over}), 32'h3);
        press_key(4'h9);
        read_display(disp);
        check("won_disp", 32'(disp), 32'h4321);
        check("won_hold", 32'({win, game_over}), 32'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
